shift_add_multiplier: RTL and testbench

Multi-cycle unsigned N×N→2N multiplier built around the team's ripple-carry N-bit adder. It takes the place of a combinational multiplier in the datapath and runs one add-and-shift step per clock. It accepts operands on a `start` pulse and presents the 2N-bit product with a one-cycle `done` strobe. Downstream logic uses it wherever area matters more than latency.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/NBitAdder_str.sv | 28 ++
 rtl/shift_add_multiplier.sv | 149 ++++++++++++++
 tb/tb_shift_add_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package.
//   ARITH_N      default operand width for the multi-cycle arithmetic blocks
//   mul_state_t  control states of the shift-and-add multiplier
//   cnt_width()  width of a step counter that must hold the values 0..n
package arith_pkg;

    localparam int unsigned ARITH_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned ARITH_CNT_W = cnt_width(ARITH_N);

endpackage

// File: rtl/NBitAdder_str.sv
// Structural N-bit ripple-carry adder.
// Ports:
//   a, b  in  N  addends
//   cin   in  1  carry in
//   sum   out N  a + b + cin, low N bits
//   cout  out 1  carry out of the top bit
module NBitAdder_str #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned N x N -> 2N shift-and-add multiplier.
// One add-and-shift step per clock through a single ripple-carry adder.
// Optional feature: define SHIFT_ADD_OVF_EN to add the registered ovf flag
// (high when the product does not fit in N bits).
// Ports:
//   clk      in  1   rising-edge clock
//   rst      in  1   synchronous active-high reset
//   start    in  1   request, sampled in IDLE or DONE
//   a        in  N   multiplicand, captured on the accepting edge
//   b        in  N   multiplier, captured on the accepting edge
//   busy     out 1   high while stepping
//   done     out 1   one-cycle strobe, product valid
//   product  out 2N  registered result, held until the next completion or rst
//   ovf      out 1   (SHIFT_ADD_OVF_EN only) |product[2N-1:N]
module shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int unsigned N = ARITH_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
`ifdef SHIFT_ADD_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam int unsigned CntW = cnt_width(N);

    mul_state_t       state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [2*N-1:0]   product_q, product_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             cout;
    logic [2*N-1:0]   acc_step;
    logic             last_step;

    // Partial sum in the upper half; add the multiplicand when the current
    // multiplier bit (lsb of acc) is set.
    assign addend = acc_q[0] ? mcand_q : '0;

    NBitAdder_str #(
        .N (N)
    ) u_adder (
        .a    (acc_q[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Carry-out re-enters at the top so the full 2N-bit product is exact.
    assign acc_step  = {cout, sum, acc_q[N-1:1]};
    assign last_step = (cnt_q == CntW'(N - 1));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    // Capture the result separately so product stays stable
                    // while acc is reloaded by a back-to-back start.
                    product_d = acc_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == BUSY);
    assign done    = (state_q == DONE);
    assign product = product_q;

`ifdef SHIFT_ADD_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == BUSY && last_step) begin
            ovf_d = |acc_step[2*N-1:N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (N = 8). The driver pushes the
// arithmetic product a*b and the issue cycle for each accepted request; the
// monitor pops on every done strobe and checks value, latency and busy count.
module tb_shift_add_multiplier;

    localparam int unsigned N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
`ifdef SHIFT_ADD_OVF_EN
    logic           ovf;
`endif

    shift_add_multiplier #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
`ifdef SHIFT_ADD_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    int             bcnt = 0;
    bit             prev_done = 0;
    logic [2*N-1:0] hold = '0;

    always @(negedge clk) begin
        if (rst) begin
            bcnt      = 0;
            prev_done = 0;
            hold      = '0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                chk("done_not_repeated", {63'd0, prev_done}, 64'd0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", 64'(product), 64'(e.prod));
                    // start presented in cycle c is sampled at the next edge;
                    // done is seen N+1 cycles after it was presented.
                    chk("latency", 64'(cyc - e.cyc), 64'(N + 1));
                    chk("busy_cycles", 64'(bcnt), 64'(N));
`ifdef SHIFT_ADD_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, (e.prod >= (2*N)'(1 << N))});
`endif
                    hold = e.prod;
                end
                bcnt = 0;
            end else if (!busy) begin
                chk("product_held", 64'(product), 64'(hold));
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input bit keep);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        e.prod = (2*N)'(x) * (2*N)'(y);
        e.cyc  = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        idle(2);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_product", 64'(product), 64'd0);
`ifdef SHIFT_ADD_OVF_EN
        chk("reset_ovf", {63'd0, ovf}, 64'd0);
`endif
        rst = 1'b0;

        // Directed cases
        issue(8'd13, 8'd11, 1'b0);  idle(N + 2);
        issue(8'd255, 8'd255, 1'b0); idle(N + 2);
        issue(8'd0, 8'd200, 1'b0);  idle(N + 2);
        issue(8'd200, 8'd0, 1'b0);  idle(N + 2);

        // start pulsed while BUSY with different operands must be ignored
        issue(8'd7, 8'd6, 1'b0);
        idle(2);
        @(negedge clk);
        start = 1'b1;
        a     = 8'd99;
        b     = 8'd99;
        @(posedge clk);
        #1 start = 1'b0;
        idle(N + 2);

        // Reset in the middle of an operation discards it
        issue(8'd9, 8'd9, 1'b0);
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        rst = 1'b0;
        issue(8'd5, 8'd5, 1'b0);
        idle(N + 2);

        // Back-to-back with start held through DONE
        issue(8'd3, 8'd4, 1'b1);
        idle(N);
        issue(8'd10, 8'd10, 1'b0);
        idle(N + 2);

        // Randomized operations with random idle gaps (0 = back-to-back)
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            issue(N'($urandom), N'($urandom), gap == 0);
            idle(N + gap);
        end
        start = 1'b0;
        idle(N + 4);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
